life_grid_sequencer: RTL and testbench

Generation sequencer for the 16x16 Game of Life engine. Owns the 256-bit grid state register, loads an initial pattern, and advances one generation per commit by capturing `grid_evolve` from the combinational `datapath` next-state block. Sits directly upstream and downstream of `datapath`: drives its `grid` input and registers its `grid_evolve` output. Supports free-run at a programmable period, single-step, and automatic halt when the pattern becomes stable.

---
 rtl/life_pkg.sv | 15 +
 rtl/period_timer.sv | 28 ++
 rtl/life_grid_sequencer.sv | 94 +++++++++
 tb/tb_life_grid_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared grid types and sequencer states for the life engine
package life_pkg;

  localparam int GRID_N = 16;
  localparam int GRID_W = GRID_N * GRID_N;

  typedef logic [GRID_W-1:0] grid_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

endpackage

// File: rtl/period_timer.sv
// rtl/period_timer.sv - free-running generation period timer
module period_timer #(
  parameter int PERIOD_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                expire
);

  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] limit;

  // A period of 0 behaves like 1; a period lowered below count runs to wrap.
  assign limit  = (period == '0) ? '0 : period - 1'b1;
  assign expire = enable && (count == limit);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= expire ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/life_grid_sequencer.sv
// rtl/life_grid_sequencer.sv - grid register and generation sequencer around datapath
module life_grid_sequencer
  import life_pkg::*;
#(
  parameter int GRID_N   = 16,
  parameter int PERIOD_W = 32,
  parameter int GEN_W    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [GRID_N*GRID_N-1:0]      init_state,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          step,
  input  logic [PERIOD_W-1:0]           period,
  output logic [GRID_N*GRID_N-1:0]      grid,
  input  logic [GRID_N*GRID_N-1:0]      grid_evolve,
  output logic                          running,
  output logic                          stable,
  output logic                          empty,
  output logic [GEN_W-1:0]              gen_count,
  output logic                          gen_tick
);

  seq_state_t state, state_next;
  logic       commit_try;
  logic       timer_clear;
  logic       expire;
  logic       unchanged;

  assign unchanged = (grid_evolve == grid);
  assign running   = (state == RUN);
  assign stable    = (state == HALTED);
  assign empty     = (grid == '0);

  period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (state == RUN),
    .period (period),
    .expire (expire)
  );

  always_comb begin
    state_next  = state;
    commit_try  = 1'b0;
    timer_clear = load;
    if (load) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // stop outranks start, so a simultaneous pair leaves us idle
          if (stop) begin
            state_next = IDLE;
          end else if (start) begin
            state_next  = RUN;
            timer_clear = 1'b1;
          end else if (step) begin
            commit_try = 1'b1;
          end
        end
        RUN: begin
          if (stop) state_next = IDLE;
          else if (expire) commit_try = 1'b1;
        end
        default: state_next = state;
      endcase
      if (commit_try && unchanged) state_next = HALTED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grid      <= '0;
      gen_count <= '0;
      gen_tick  <= 1'b0;
    end else begin
      state    <= state_next;
      gen_tick <= commit_try && !unchanged;
      if (load) begin
        grid      <= init_state;
        gen_count <= '0;
      end else if (commit_try && !unchanged) begin
        grid      <= grid_evolve;
        gen_count <= gen_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_life_grid_sequencer.sv
// tb/tb_life_grid_sequencer.sv - directed self-checking bench for life_grid_sequencer
module tb_life_grid_sequencer;

  logic         clk = 1'b0;
  logic         reset, load, start, stop, step;
  logic [255:0] init_state, grid, grid_evolve;
  logic [31:0]  period;
  logic         running, stable, empty, gen_tick;
  logic [15:0]  gen_count;

  int vectors = 0;
  int miscompares = 0;

  logic [255:0] blink_h, blink_v, block;

  always #5 clk = ~clk;

  life_grid_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .init_state  (init_state),
    .start       (start),
    .stop        (stop),
    .step        (step),
    .period      (period),
    .grid        (grid),
    .grid_evolve (grid_evolve),
    .running     (running),
    .stable      (stable),
    .empty       (empty),
    .gen_count   (gen_count),
    .gen_tick    (gen_tick)
  );

  // Reference Game of Life rule with dead cells outside the grid.
  function automatic logic [255:0] life_next(input logic [255:0] g);
    logic [255:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 16 && c + dc >= 0 && c + dc < 16)
              cnt += int'(g[(r + dr) * 16 + c + dc]);
          end
        end
        n[r * 16 + c] = (cnt == 3) || (g[r * 16 + c] && cnt == 2);
      end
    end
    return n;
  endfunction

  always_comb grid_evolve = life_next(grid);

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [255:0] pat);
    init_state = pat;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    blink_h = 256'h0070 << 80;
    blink_v = (256'h0020 << 64) | (256'h0020 << 80) | (256'h0020 << 96);
    block   = (256'h0030 << 80) | (256'h0030 << 96);
    reset = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
    init_state = '0; period = 32'd4;

    tick(2);
    reset = 1'b0;
    chk("reset_grid", grid, '0);
    chk("reset_gen", 256'(gen_count), 256'd0);
    chk("reset_running", 256'(running), 256'd0);
    chk("reset_stable", 256'(stable), 256'd0);
    chk("reset_empty", 256'(empty), 256'd1);
    chk("reset_tick", 256'(gen_tick), 256'd0);

    do_load(blink_h);
    chk("load_grid", grid, blink_h);
    chk("load_empty", 256'(empty), 256'd0);

    step = 1'b1; tick(); step = 1'b0;
    chk("step1_grid", grid, blink_v);
    chk("step1_gen", 256'(gen_count), 256'd1);
    chk("step1_tick", 256'(gen_tick), 256'd1);
    tick();
    chk("step1_tick_drop", 256'(gen_tick), 256'd0);
    step = 1'b1; tick(); step = 1'b0;
    chk("step2_grid", grid, blink_h);
    chk("step2_gen", 256'(gen_count), 256'd2);

    do_load(blink_h);
    period = 32'd4;
    start = 1'b1; tick(); start = 1'b0;
    chk("run_running", 256'(running), 256'd1);
    tick(3);
    chk("run_edge3_gen", 256'(gen_count), 256'd0);
    tick();
    chk("run_edge4_gen", 256'(gen_count), 256'd1);
    chk("run_edge4_tick", 256'(gen_tick), 256'd1);
    chk("run_edge4_grid", grid, blink_v);
    tick();
    chk("run_edge5_tick", 256'(gen_tick), 256'd0);
    tick(3);
    chk("run_edge8_gen", 256'(gen_count), 256'd2);
    tick(4);
    chk("run_edge12_gen", 256'(gen_count), 256'd3);
    chk("run_edge12_grid", grid, blink_v);
    tick(3);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_gen", 256'(gen_count), 256'd3);
    chk("stop_running", 256'(running), 256'd0);
    chk("stop_tick", 256'(gen_tick), 256'd0);

    do_load(blink_h);
    period = 32'd0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("p0_gen1", 256'(gen_count), 256'd1);
    tick();
    chk("p0_gen2", 256'(gen_count), 256'd2);
    chk("p0_tick_back2back", 256'(gen_tick), 256'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("p0_stop_gen", 256'(gen_count), 256'd2);

    do_load(block);
    period = 32'd1;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("still_stable", 256'(stable), 256'd1);
    chk("still_running", 256'(running), 256'd0);
    chk("still_gen", 256'(gen_count), 256'd0);
    chk("still_grid", grid, block);
    start = 1'b1; tick(); start = 1'b0;
    step = 1'b1; tick(); step = 1'b0;
    chk("halted_ignore_stable", 256'(stable), 256'd1);
    chk("halted_ignore_running", 256'(running), 256'd0);
    chk("halted_ignore_gen", 256'(gen_count), 256'd0);
    do_load(block);
    chk("load_clears_stable", 256'(stable), 256'd0);

    do_load('0);
    step = 1'b1; tick(); step = 1'b0;
    chk("empty_empty", 256'(empty), 256'd1);
    chk("empty_stable", 256'(stable), 256'd1);
    chk("empty_tick", 256'(gen_tick), 256'd0);

    do_load(blink_h);
    period = 32'd4;
    start = 1'b1; tick(); start = 1'b0;
    tick(4);
    chk("midload_pre_gen", 256'(gen_count), 256'd1);
    tick(2);
    do_load(blink_h);
    chk("midload_running", 256'(running), 256'd0);
    chk("midload_gen", 256'(gen_count), 256'd0);
    chk("midload_grid", grid, blink_h);
    start = 1'b1; tick(); start = 1'b0;
    tick(3);
    chk("rerun_edge3_gen", 256'(gen_count), 256'd0);
    tick();
    chk("rerun_edge4_gen", 256'(gen_count), 256'd1);
    tick(2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midreset_grid", grid, '0);
    chk("midreset_gen", 256'(gen_count), 256'd0);
    chk("midreset_running", 256'(running), 256'd0);
    chk("midreset_stable", 256'(stable), 256'd0);
    chk("midreset_empty", 256'(empty), 256'd1);
    chk("midreset_tick", 256'(gen_tick), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
